// File: rtl/sd4_pp_accum_tree.sv
`default_nettype none
// ============================================================================
// Module   : sd4_pp_accum_tree
// Purpose  : Pipelined SD4 partial-product reduction tree feeding a packet
//            accumulator (one group per cycle, result per packet).
// Revision : 1.0 - initial release
// ============================================================================
module sd4_pp_accum_tree #(
  parameter int PP_W  = 16,
  parameter int N_PP  = 9,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [N_PP*PP_W-1:0]   pp_bus,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out_sum,
  output logic [15:0]            out_count,
  output logic                   out_ovf
);

  localparam int c_d     = $clog2(N_PP);
  localparam int c_sum_w = PP_W + c_d;

  // Operands beyond a level's live count are held at zero, so pairing an odd
  // leftover with its zero neighbour is exactly the 1-bit sign-extended
  // pass-through. Sums are formed at the full tree width, which never
  // overflows and therefore matches level-by-level width growth bit for bit.
  logic signed [c_sum_w-1:0] w_src [0:c_d-1][0:2*N_PP-1];
  logic signed [c_sum_w-1:0] r_lvl [1:c_d][0:N_PP-1];

  logic [c_d:1] r_v, r_f, r_l;
  logic [c_d:0] w_vin, w_fin, w_lin;

  logic signed [ACC_W-1:0] r_acc, w_ext, w_add, w_acc_nx;
  logic [15:0]             r_cnt, w_cnt_nx;
  logic                    r_ovf, w_ovf_nx, w_add_ovf;

  logic                    r_out_valid;
  logic [ACC_W-1:0]        r_out_sum;
  logic [15:0]             r_out_count;
  logic                    r_out_ovf;

  assign w_vin = {r_v, in_valid};
  assign w_fin = {r_f, in_first};
  assign w_lin = {r_l, in_last};

  always_comb begin
    for (int k = 0; k < c_d; k++)
      for (int i = 0; i < 2*N_PP; i++)
        w_src[k][i] = '0;
    for (int i = 0; i < N_PP; i++)
      w_src[0][i] = c_sum_w'($signed(pp_bus[i*PP_W +: PP_W]));
    for (int k = 1; k < c_d; k++)
      for (int i = 0; i < N_PP; i++)
        w_src[k][i] = r_lvl[k][i];
  end

  // Tree data registers load only when the group in front of them is valid.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= c_d; k++) begin
      if (w_vin[k-1]) begin
        for (int j = 0; j < N_PP; j++)
          r_lvl[k][j] <= w_src[k-1][2*j] + w_src[k-1][2*j+1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_f <= '0;
      r_l <= '0;
    end else begin
      r_v <= w_vin[c_d-1:0];
      r_f <= w_fin[c_d-1:0];
      r_l <= w_lin[c_d-1:0];
    end
  end

  assign w_ext     = ACC_W'(r_lvl[c_d][0]);
  assign w_add     = r_acc + w_ext;
  assign w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                     (w_add[ACC_W-1] != r_acc[ACC_W-1]);

  always_comb begin
    w_acc_nx = w_add;
    w_cnt_nx = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    w_ovf_nx = r_ovf | w_add_ovf;
    if (w_fin[c_d]) begin
      w_acc_nx = w_ext;
      w_cnt_nx = 16'd1;
      w_ovf_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_out_valid <= w_vin[c_d] & w_lin[c_d];
      if (w_vin[c_d]) begin
        r_acc <= w_acc_nx;
        r_cnt <= w_cnt_nx;
        r_ovf <= w_ovf_nx;
        if (w_lin[c_d]) begin
          r_out_sum   <= w_acc_nx;
          r_out_count <= w_cnt_nx;
          r_out_ovf   <= w_ovf_nx;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sd4_pp_accum_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd4_pp_accum_tree
// Purpose  : Self-checking bench: three tree configurations against a
//            packet-level arithmetic model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd4_pp_accum_tree;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv = 1'b0, ifst = 1'b0, ilst = 1'b0;
  logic [143:0] bus = '0;

  logic        v0, v1, v2, o0, o1, o2;
  logic [31:0] s0, s2;
  logic [19:0] s1;
  logic [15:0] c0, c1, c2;

  sd4_pp_accum_tree #(.PP_W(16), .N_PP(9), .ACC_W(32)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_first(ifst), .in_last(ilst),
    .pp_bus(bus), .out_valid(v0), .out_sum(s0), .out_count(c0), .out_ovf(o0));
  sd4_pp_accum_tree #(.PP_W(16), .N_PP(9), .ACC_W(20)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_first(ifst), .in_last(ilst),
    .pp_bus(bus), .out_valid(v1), .out_sum(s1), .out_count(c1), .out_ovf(o1));
  sd4_pp_accum_tree #(.PP_W(16), .N_PP(5), .ACC_W(32)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_first(ifst), .in_last(ilst),
    .pp_bus(bus[79:0]), .out_valid(v2), .out_sum(s2), .out_count(c2), .out_ovf(o2));

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int tests = 0, fails = 0, last_e0 = 0;

  typedef struct { int t; longint s; int c; bit o; } exp_t;
  exp_t   q [3][$];
  longint macc [3];
  int     mcnt [3];
  bit     movf [3];
  int     c_w   [3] = '{32, 20, 32};
  int     c_lat [3] = '{4, 4, 3};

  function automatic longint wrapw(input longint x, input int w);
    longint one = 1;
    longint m   = one << w;
    longint r   = x & (m - 1);
    if (r >= (m >> 1)) r -= m;
    return r;
  endfunction

  function automatic longint dv(input int d);
    return (d == 0) ? longint'(v0) : (d == 1) ? longint'(v1) : longint'(v2);
  endfunction
  function automatic longint ds(input int d);
    return (d == 0) ? longint'($signed(s0)) : (d == 1) ? longint'($signed(s1)) : longint'($signed(s2));
  endfunction
  function automatic longint dc(input int d);
    return (d == 0) ? longint'(c0) : (d == 1) ? longint'(c1) : longint'(c2);
  endfunction
  function automatic longint dovf(input int d);
    return (d == 0) ? longint'(o0) : (d == 1) ? longint'(o1) : longint'(o2);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  // Packet-level reference: plain integer sums, wrap to ACC_W, overflow when
  // the wrapped result differs from the exact one.
  task automatic model_group(input bit f, input bit l, input logic [143:0] b, input int e0);
    longint s9 = 0, s5 = 0, s, raw, nw;
    for (int k = 0; k < 9; k++) begin
      longint p = longint'($signed(b[k*16 +: 16]));
      s9 += p;
      if (k < 5) s5 += p;
    end
    for (int c = 0; c < 3; c++) begin
      s = (c == 2) ? s5 : s9;
      if (f) begin
        macc[c] = wrapw(s, c_w[c]); mcnt[c] = 1; movf[c] = 1'b0;
      end else begin
        raw = macc[c] + s;
        nw  = wrapw(raw, c_w[c]);
        if (nw != raw) movf[c] = 1'b1;
        macc[c] = nw;
        mcnt[c] = (mcnt[c] >= 65535) ? 65535 : mcnt[c] + 1;
      end
      if (l) q[c].push_back('{e0 + c_lat[c], macc[c], mcnt[c], movf[c]});
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      q[c].delete(); macc[c] = 0; mcnt[c] = 0; movf[c] = 1'b0;
    end
  endtask

  task automatic drive(input bit f, input bit l, input logic [143:0] b);
    iv = 1'b1; ifst = f; ilst = l; bus = b;
    last_e0 = ecount + 1;
    model_group(f, l, b, last_e0);
    @(negedge clk);
    iv = 1'b0; ifst = 1'b0; ilst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_lit(input string nm, input int d, input int tgt,
                            input longint s, input longint c, input longint o);
    while (ecount < tgt) @(negedge clk);
    check({nm, "_valid"}, dv(d), 1);
    check({nm, "_sum"},   ds(d), s);
    check({nm, "_count"}, dc(d), c);
    check({nm, "_ovf"},   dovf(d), o);
  endtask

  task automatic check_zero(input string nm);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_valid%0d", nm, d), dv(d), 0);
      check($sformatf("%s_sum%0d", nm, d),   ds(d), 0);
      check($sformatf("%s_count%0d", nm, d), dc(d), 0);
      check($sformatf("%s_ovf%0d", nm, d),   dovf(d), 0);
    end
  endtask

  function automatic logic [143:0] fill(input logic [15:0] v);
    logic [143:0] b;
    for (int k = 0; k < 9; k++) b[k*16 +: 16] = v;
    return b;
  endfunction

  function automatic logic [143:0] rnd();
    logic [143:0] b;
    for (int k = 0; k < 9; k++) b[k*16 +: 16] = 16'($urandom);
    return b;
  endfunction

  function automatic logic [143:0] single(input logic [15:0] v);
    logic [143:0] b = '0;
    b[15:0] = v;
    return b;
  endfunction

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    exp_t e;
    bit   expv;
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        expv = (q[c].size() > 0) && (q[c][0].t == ecount);
        check($sformatf("out_valid[%0d]", c), dv(c), longint'(expv));
        if (expv) begin
          e = q[c].pop_front();
          check($sformatf("out_sum[%0d]", c),   ds(c), e.s);
          check($sformatf("out_count[%0d]", c), dc(c), longint'(e.c));
          check($sformatf("out_ovf[%0d]", c),   dovf(c), longint'(e.o));
        end
      end
    end
  end

  initial begin
    logic [143:0] b;
    int e;
    model_reset();
    idle(3);
    check_zero("reset");
    rst = 1'b0;

    drive(1'b1, 1'b1, fill(16'd1));
    e = last_e0;
    expect_lit("ones_n5", 2, e + 3, 5, 1, 0);
    expect_lit("ones_n9", 0, e + 4, 9, 1, 0);

    drive(1'b1, 1'b1, fill(16'h8000));
    e = last_e0;
    expect_lit("minneg_n5", 2, e + 3, -163840, 1, 0);
    expect_lit("minneg_n9", 0, e + 4, -294912, 1, 0);

    for (int k = 0; k < 9; k++) b[k*16 +: 16] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
    drive(1'b1, 1'b1, b);
    expect_lit("alt_n9", 0, last_e0 + 4, 32763, 1, 0);

    drive(1'b1, 1'b0, single(16'd100));
    drive(1'b0, 1'b0, single(-16'sd250));
    drive(1'b0, 1'b1, single(16'd7));
    expect_lit("three_grp", 0, last_e0 + 4, -143, 3, 0);

    drive(1'b1, 1'b0, fill(16'h7FFF));
    drive(1'b0, 1'b1, fill(16'h7FFF));
    expect_lit("wrap_a20", 1, last_e0 + 4, -458770, 2, 1);
    drive(1'b1, 1'b1, fill(16'd1));
    expect_lit("after_wrap_a20", 1, last_e0 + 4, 9, 1, 0);

    b = '0;
    b[15:0] = 16'd1; b[31:16] = 16'd2; b[47:32] = 16'd3; b[63:48] = 16'd4; b[79:64] = 16'hFFFB;
    drive(1'b1, 1'b1, b);
    expect_lit("n5_mix", 2, last_e0 + 3, 5, 1, 0);

    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, rnd());
    idle(6);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) != 0)
        drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rnd());
      else
        idle(1);
    end
    idle(6);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rnd());
    iv = 1'b1; ifst = 1'b1; ilst = 1'b1; bus = rnd();
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    iv = 1'b0; ifst = 1'b0; ilst = 1'b0;
    idle(2);
    #2 rst = 1'b0;
    @(negedge clk);

    drive(1'b0, 1'b0, single(16'd40));
    drive(1'b0, 1'b1, single(16'd2));
    expect_lit("no_open", 0, last_e0 + 4, 42, 2, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, rnd());
      else
        idle(1);
    end
    idle(8);
    for (int c = 0; c < 3; c++)
      check($sformatf("drain[%0d]", c), longint'(q[c].size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
